// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_TH  = 60,
    parameter int AEMPTY_TH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_counter,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_ok, rd_ok;

    assign buf_empty    = cnt_q == '0;
    assign buf_full     = cnt_q == DEPTH_C;
    assign almost_full  = cnt_q >= AFULL_C;
    assign almost_empty = cnt_q <= AEMPTY_C;
    assign fifo_counter = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign buf_out      = FWFT ? (buf_empty ? '0 : mem_q[rd_ptr_q]) : out_q;

    // Flush masks both requests, so a flushing cycle neither moves data nor raises errors.
    always_comb begin
        rd_ok    = !flush && rd_en && !buf_empty;
        wr_ok    = !flush && wr_en && (!buf_full || rd_ok);
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(rd_ok);
        cnt_d    = flush ? '0 : cnt_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
        out_d    = flush ? '0 : rd_ok ? mem_q[rd_ptr_q] : out_q;
        ovf_d    = !flush && (ovf_q || (wr_en && !wr_ok));
        udf_d    = !flush && (udf_q || (rd_en && !rd_ok));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= buf_in;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a registered-read and a FWFT instance with identical traffic
// and compares both against a queue-based model of the FIFO.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] buf_in = 8'h00;

    logic [7:0] out0, out1;
    logic       e0, f0, af0, ae0, ov0, un0;
    logic       e1, f1, af1, ae1, ov1, un1;
    logic [6:0] c0, c1;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] mq[$];
    logic [7:0] m_out;
    logic       m_ovf, m_udf;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
        .buf_out(out0), .buf_empty(e0), .buf_full(f0), .almost_full(af0), .almost_empty(ae0),
        .fifo_counter(c0), .overflow(ov0), .underflow(un0)
    );

    sync_fifo_param #(.FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
        .buf_out(out1), .buf_empty(e1), .buf_full(f1), .almost_full(af1), .almost_empty(ae1),
        .fifo_counter(c1), .overflow(ov1), .underflow(un1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_out = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock of FIFO semantics: reads see the pre-edge contents, then the write lands.
    task automatic model_step(input logic f, input logic w, input logic r, input logic [7:0] d);
        bit full, empty, rok, wok;
        if (f) begin
            model_clear();
            return;
        end
        full  = mq.size() == 64;
        empty = mq.size() == 0;
        rok   = r && !empty;
        wok   = w && (!full || rok);
        if (r && !rok) m_udf = 1'b1;
        if (w && !wok) m_ovf = 1'b1;
        if (rok) m_out = mq.pop_front();
        if (wok) mq.push_back(d);
    endtask

    task automatic check_inst(input string n, input logic [7:0] o, input logic e, input logic f,
                              input logic af, input logic ae, input logic [6:0] c,
                              input logic ov, input logic un, input logic [7:0] exp_out);
        int sz;
        sz = mq.size();
        check({n, ".cnt"},   32'(c),  32'(sz));
        check({n, ".empty"}, 32'(e),  32'(sz == 0));
        check({n, ".full"},  32'(f),  32'(sz == 64));
        check({n, ".afull"}, 32'(af), 32'(sz >= 60));
        check({n, ".aempt"}, 32'(ae), 32'(sz <= 4));
        check({n, ".ovf"},   32'(ov), 32'(m_ovf));
        check({n, ".udf"},   32'(un), 32'(m_udf));
        check({n, ".out"},   32'(o),  32'(exp_out));
    endtask

    task automatic compare();
        check_inst("reg", out0, e0, f0, af0, ae0, c0, ov0, un0, m_out);
        check_inst("fwft", out1, e1, f1, af1, ae1, c1, ov1, un1, mq.size() == 0 ? 8'h00 : mq[0]);
    endtask

    task automatic cyc(input logic f, input logic w, input logic r, input logic [7:0] d);
        flush  = f;
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        @(posedge clk);
        model_step(f, w, r, d);
        #1;
        compare();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_clear();
        compare();
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare();
        // Three words in, three out; registered data lags each rd_en by a cycle.
        cyc(0, 1, 0, 8'h11);
        cyc(0, 1, 0, 8'h22);
        cyc(0, 1, 0, 8'h33);
        repeat (3) cyc(0, 0, 1, 8'h00);
        // Fill to full, reject one extra write, drain, then wrap the pointers.
        for (int i = 0; i < 64; i++) cyc(0, 1, 0, 8'(i));
        cyc(0, 1, 0, 8'hEE);
        repeat (64) cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'(8'h80 + i));
        repeat (10) cyc(0, 0, 1, 8'h00);
        // Simultaneous push/pop at full, then at empty.
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) cyc(0, 1, 0, 8'(8'h40 + i));
        cyc(0, 1, 1, 8'hA5);
        repeat (64) cyc(0, 0, 1, 8'h00);
        cyc(0, 1, 1, 8'h77);
        cyc(0, 0, 1, 8'h00);
        // FWFT visibility without rd_en.
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h5A);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);
        // Flush with a concurrent write at count 20.
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 8'(8'hC0 + i));
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 1, 0, 8'hD0);
        cyc(0, 1, 0, 8'hD1);
        cyc(1, 1, 0, 8'hFF);
        cyc(0, 0, 0, 8'h00);
        // Asynchronous reset between edges, then restart.
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(8'h30 + i));
        async_reset();
        cyc(0, 1, 0, 8'h9C);
        cyc(0, 0, 1, 8'h00);
        // Random traffic with alternating fill/drain bias.
        for (int i = 0; i < 800; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 75 : 30;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 99) < wp,
                $urandom_range(0, 99) < 50, 8'($urandom));
            if (i == 400) async_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 8-bit/64-entry buffer. Generalises data width and depth. Adds:
- programmable almost-full/almost-empty thresholds
- selectable first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow/underflow error flags

Sits between byte/word producers and consumers in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 6, pointer width; depth DEPTH = 2**ADDR_W (64)
AFULL_TH, 60, almost_full asserts when fifo_counter >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserts when fifo_counter <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on buf_out without rd_en

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous clear of contents, pointers and error flags
wr_en  input  1  write request
buf_in  input  DATA_W  write data
rd_en  input  1  read request (pop)
buf_out  output  DATA_W  read data
buf_empty  output  1  fifo_counter == 0
buf_full  output  1  fifo_counter == DEPTH
almost_full  output  1  fifo_counter >= AFULL_TH
almost_empty  output  1  fifo_counter <= AEMPTY_TH
fifo_counter  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write was rejected
underflow  output  1  sticky: read was rejected

Behaviour:
- Reset (rst high, async): wr_ptr, rd_ptr and fifo_counter clear to 0; buf_out = 0; overflow = underflow = 0. Flag values follow: buf_empty = 1, almost_empty = 1, buf_full = 0, almost_full = 0 (for AFULL_TH >= 1). Memory contents are not reset.
- Flags are decoded from the registered fifo_counter and update in the same cycle as the counter.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Occupancy comes from fifo_counter only, never from pointer comparison.
- Accepted write (wr_ok): wr_en && (!buf_full || rd_ok). Writes buf_in to mem[wr_ptr] and increments wr_ptr.
- Accepted read (rd_ok): rd_en && !buf_empty. Increments rd_ptr.
- Counter update:
  - wr_ok only: +1
  - rd_ok only: -1
  - both: unchanged
- Full with wr_en and rd_en together: both accepted, count stays DEPTH, no overflow.
- Empty with wr_en and rd_en together: write accepted, read rejected, underflow set, count becomes 1.
- overflow sets on wr_en && !wr_ok. underflow sets on rd_en && !rd_ok. Both hold until rst or flush. Rejected operations change no pointer, counter or memory.
- FWFT=0 mode:
  - on rd_ok, buf_out <= mem[rd_ptr] at that edge, so data is valid the cycle after the rd_en cycle
  - buf_out holds otherwise, including on a rejected read
- FWFT=1 mode:
  - buf_out = mem[rd_ptr] combinationally while !buf_empty; rd_en pops that word
  - buf_out = 0 while empty
  - a word written into an empty FIFO appears on buf_out the cycle after the write edge
- flush (sync, sampled at clk edge): same effect as reset, except memory is untouched. Has priority over wr_en/rd_en in the same cycle; neither is accepted and no error flag sets.
- rst asserted mid-operation: state clears immediately regardless of clk. The first accepted operation after deassertion starts at pointer 0.
- Illegal parameters (AFULL_TH > DEPTH, AEMPTY_TH >= DEPTH) are rejected at elaboration.

Test Plan:
- Reset then idle: rst pulse -> fifo_counter=0, buf_empty=1, almost_empty=1, buf_full=0, overflow=0, underflow=0, buf_out=0.
- FWFT=0: write 0x11,0x22,0x33 on 3 cycles, then rd_en 3 cycles -> buf_out = 0x11,0x22,0x33, each one cycle after its rd_en; counter 3→0; buf_empty=1 at end.
- Fill and wrap: write 64 words 0x00..0x3F -> buf_full=1; almost_full=1 from count 60. 65th write -> rejected, overflow=1, counter=64. Read 64 -> data 0x00..0x3F in order. Write and read 10 more -> pointers wrap, data intact.
- Simultaneous ops:
  - at count 64, wr_en+rd_en with 0xA5 -> counter stays 64, overflow stays 0, 0xA5 read out last
  - at count 0, wr_en+rd_en -> counter=1, underflow=1
- FWFT=1: write 0x5A into empty FIFO -> buf_out=0x5A the next cycle with no rd_en; rd_en -> buf_empty=1, buf_out=0.
- Flush/reset mid-stream: at count 20, flush together with wr_en -> next cycle counter=0, errors cleared, write ignored. Async rst between clock edges -> counter=0 immediately.
